// File: rtl/hack_pkg.sv
// hack_pkg: shared constants for the Hack dmux family.
//   SEL_A..SEL_D  : destination encodings of the 2-bit select
//   DEFAULT_WIDTH : default data width of the routed value
package hack_pkg;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;
  localparam logic [1:0] SEL_D = 2'd3;

  localparam int DEFAULT_WIDTH = 1;

endpackage

// File: rtl/hack_dmux_2way.sv
// hack_dmux_2way: one-input, two-output demultiplexer (Hack DMux gate).
//   in  [WIDTH] : data to route
//   sel [1]     : 0 -> a, 1 -> b
//   a, b [WIDTH]: routed copy of in on the selected output, zero on the other
// Pure combinational logic; an unknown sel propagates X on the bits where
// in is 1 rather than being forced to either output.
module hack_dmux_2way
  import hack_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] in,
  input  logic             sel,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b
);

  assign a = sel ? {WIDTH{1'b0}} : in;
  assign b = sel ? in : {WIDTH{1'b0}};

endmodule

// File: rtl/hack_dmux_4_way.sv
// hack_dmux_4_way: one-input, four-output demultiplexer with registered copy.
//   clk            : single clock, registered outputs update on its rising edge
//   rst            : synchronous active-high reset of the registered outputs
//   in  [WIDTH]    : data to route
//   sel [2]        : 0 -> a, 1 -> b, 2 -> c, 3 -> d
//   a..d [WIDTH]   : combinational outputs, only the selected one carries in
//   a_q..d_q [WIDTH]: the same outputs delayed by one clock, cleared by rst
// The decode is a two-level tree: sel[1] picks the low {a,b} or high {c,d}
// pair, then sel[0] picks within the pair. The combinational path ignores
// clk and rst entirely, so it stays valid while reset is held.
module hack_dmux_4_way
  import hack_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] c_q,
  output logic [WIDTH-1:0] d_q
);

  logic [WIDTH-1:0] low_pair_s;
  logic [WIDTH-1:0] high_pair_s;

  // First level: sel[1] chooses which pair receives the data.
  hack_dmux_2way #(.WIDTH(WIDTH)) u_pair_split (
    .in  (in),
    .sel (sel[1]),
    .a   (low_pair_s),
    .b   (high_pair_s)
  );

  // Second level, low pair: sel[0] chooses a or b.
  hack_dmux_2way #(.WIDTH(WIDTH)) u_low_pair (
    .in  (low_pair_s),
    .sel (sel[0]),
    .a   (a),
    .b   (b)
  );

  // Second level, high pair: sel[0] chooses c or d.
  hack_dmux_2way #(.WIDTH(WIDTH)) u_high_pair (
    .in  (high_pair_s),
    .sel (sel[0]),
    .a   (c),
    .b   (d)
  );

  // Output register bank: capture the settled combinational outputs each edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= {WIDTH{1'b0}};
      b_q <= {WIDTH{1'b0}};
      c_q <= {WIDTH{1'b0}};
      d_q <= {WIDTH{1'b0}};
    end else begin
      a_q <= a;
      b_q <= b;
      c_q <= c;
      d_q <= d;
    end
  end

endmodule

// File: tb/tb_hack_dmux_4_way.sv
// Self-checking bench for hack_dmux_4_way: a WIDTH=16 instance driven with
// directed and random stimulus against a behavioural model, plus a WIDTH=1
// instance swept exhaustively on its combinational path.
module tb_hack_dmux_4_way;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W-1:0] in;
  logic [1:0]   sel;
  logic [W-1:0] a, b, c, d, a_q, b_q, c_q, d_q;

  logic [0:0]   in1;
  logic [1:0]   sel1;
  logic [0:0]   a1, b1, c1, d1, a1_q, b1_q, c1_q, d1_q;

  int checks = 0;
  int errors = 0;

  hack_dmux_4_way #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in(in), .sel(sel),
    .a(a), .b(b), .c(c), .d(d),
    .a_q(a_q), .b_q(b_q), .c_q(c_q), .d_q(d_q)
  );

  hack_dmux_4_way #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in(in1), .sel(sel1),
    .a(a1), .b(b1), .c(c1), .d(d1),
    .a_q(a1_q), .b_q(b1_q), .c_q(c1_q), .d_q(d1_q)
  );

  logic [W-1:0] comb_v [4];
  logic [W-1:0] q_v [4];
  assign comb_v[0] = a;   assign comb_v[1] = b;   assign comb_v[2] = c;   assign comb_v[3] = d;
  assign q_v[0]    = a_q; assign q_v[1]    = b_q; assign q_v[2]    = c_q; assign q_v[3]    = d_q;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference rule: output k carries the data exactly when sel equals k.
  function automatic logic [W-1:0] route(input int k, input logic [W-1:0] v, input logic [1:0] s);
    return (int'(s) == k) ? v : {W{1'b0}};
  endfunction

  // Model of the registered outputs: one-cycle delayed route, cleared by reset.
  logic [W-1:0] exp_q [4];
  logic         model_valid = 1'b0;
  logic         comp_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) exp_q[k] <= {W{1'b0}};
      model_valid <= 1'b1;
    end else begin
      for (int k = 0; k < 4; k++) exp_q[k] <= route(k, in, sel);
    end
  end

  // Compare process: every falling edge, check both paths and the one-hot rule.
  always @(negedge clk) begin
    if (comp_en && model_valid) begin
      int nz;
      nz = 0;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("comb[%0d] sel=%0d", k, sel), comb_v[k], route(k, in, sel));
        chk($sformatf("q[%0d]", k), q_v[k], exp_q[k]);
        if (q_v[k] != {W{1'b0}}) nz++;
      end
      checks++;
      if (nz > 1) begin
        errors++;
        $display("FAIL onehot_q: got %0d non-zero registered outputs expected at most 1", nz);
      end
    end
  end

  initial begin
    logic [3:0] exp4;
    rst  = 1'b1;
    in   = {W{1'b0}};
    sel  = 2'd0;
    in1  = 1'b0;
    sel1 = 2'd0;

    // Exhaustive WIDTH=1 combinational sweep, valid even while reset is held.
    for (int iv = 0; iv < 2; iv++) begin
      for (int s = 0; s < 4; s++) begin
        in1  = iv[0:0];
        sel1 = s[1:0];
        #1;
        exp4 = (iv == 1) ? (4'b0001 << s) : 4'b0000;
        chk($sformatf("w1 {d,c,b,a} in=%0d sel=%0d", iv, s), {12'h000, d1, c1, b1, a1}, {12'h000, exp4});
      end
    end

    repeat (2) @(posedge clk);
    #1;
    chk("w1 q after reset", {12'h000, d1_q, c1_q, b1_q, a1_q}, 16'h0000);
    chk("w16 q after reset", a_q | b_q | c_q | d_q, 16'h0000);
    rst     = 1'b0;
    comp_en = 1'b1;

    // WIDTH=16 pattern routed to c.
    in  = 16'hA5C3;
    sel = 2'd2;
    #1;
    chk("c=A5C3", c, 16'hA5C3);
    chk("a|b|d zero", a | b | d, 16'h0000);
    @(posedge clk); #1;
    chk("c_q=A5C3", c_q, 16'hA5C3);
    chk("a_q|b_q|d_q zero", a_q | b_q | d_q, 16'h0000);

    // Reset while routing to d: registers clear, combinational path unaffected.
    in  = 16'h0001;
    sel = 2'd3;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("d during reset", d, 16'h0001);
    chk("q cleared by reset", a_q | b_q | c_q | d_q, 16'h0000);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("d_q after reset release", d_q, 16'h0001);

    // Step sel 0..3 with in=1: registered output tracks one edge later.
    for (int s = 0; s < 4; s++) begin
      sel = s[1:0];
      @(posedge clk); #1;
      chk($sformatf("step q[%0d]", s), q_v[s], 16'h0001);
    end

    // Random traffic with occasional resets.
    repeat (300) begin
      in  = W'($urandom);
      sel = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); #1;
    comp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
